// File: rtl/spike_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spike_sched_pkg
//  Purpose  : Shared types and default widths for the spike tick scheduler.
//             The FSM state encoding, the latched run configuration record
//             and the default bus widths live here so the scheduler and its
//             profiling helper agree on them.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package spike_sched_pkg;

  localparam int SCHED_TICK_W = 8;   // tick bus width of the spike core
  localparam int SCHED_GAP_W  = 8;   // inter-tick idle gap counter width
  localparam int SCHED_PROF_W = 32;  // profiling counter width

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_GAP     = 3'd3,
    ST_ADVANCE = 3'd4,
    ST_FINISH  = 3'd5
  } sched_state_e;

  // Run configuration captured on an accepted start.
  typedef struct packed {
    logic [SCHED_TICK_W:0]   num_ticks;
    logic [SCHED_GAP_W-1:0]  tick_gap;
  } sched_cfg_t;

endpackage
`default_nettype wire

// File: rtl/spike_tick_prof.sv
`default_nettype none
// ============================================================================
//  Module   : spike_tick_prof
//  Purpose  : Saturating profiling counters for the tick scheduler.
//             tick_cycles_o holds the length (RUN entry to DRAIN exit) of the
//             most recently completed tick; run_cycles_o counts the active
//             cycles of the current/last run. Both clear on clr_i.
//  Ports    : CLK, RSTN        clock, async active-low reset
//             clr_i            clear all counters (accepted start)
//             tick_en_i        current tick is in RUN or DRAIN
//             tick_end_i       DRAIN exit of the current tick
//             run_en_i         run in progress (not IDLE, not FINISH)
//             tick_cycles_o    last completed tick length
//             run_cycles_o     run length
//  Revision : 1.0 - initial release
// ============================================================================
module spike_tick_prof #(
  parameter int PROF_W = 32
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              clr_i,
  input  logic              tick_en_i,
  input  logic              tick_end_i,
  input  logic              run_en_i,
  output logic [PROF_W-1:0] tick_cycles_o,
  output logic [PROF_W-1:0] run_cycles_o
);

  localparam logic [PROF_W-1:0] C_SAT_MAX = '1;

  function automatic logic [PROF_W-1:0] sat_inc(input logic [PROF_W-1:0] v);
    return (v == C_SAT_MAX) ? v : v + PROF_W'(1);
  endfunction

  logic [PROF_W-1:0] cur_q, cur_d;
  logic [PROF_W-1:0] tick_cycles_q, tick_cycles_d;
  logic [PROF_W-1:0] run_cycles_q, run_cycles_d;

  always_comb begin
    cur_d         = cur_q;
    tick_cycles_d = tick_cycles_q;
    run_cycles_d  = run_cycles_q;
    if (clr_i) begin
      cur_d         = '0;
      tick_cycles_d = '0;
      run_cycles_d  = '0;
    end else begin
      if (run_en_i) begin
        run_cycles_d = sat_inc(run_cycles_q);
      end
      // The exit cycle itself belongs to the tick being closed.
      if (tick_end_i) begin
        tick_cycles_d = sat_inc(cur_q);
        cur_d         = '0;
      end else if (tick_en_i) begin
        cur_d = sat_inc(cur_q);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cur_q         <= '0;
      tick_cycles_q <= '0;
      run_cycles_q  <= '0;
    end else begin
      cur_q         <= cur_d;
      tick_cycles_q <= tick_cycles_d;
      run_cycles_q  <= run_cycles_d;
    end
  end

  assign tick_cycles_o = tick_cycles_q;
  assign run_cycles_o  = run_cycles_q;

endmodule
`default_nettype wire

// File: rtl/spike_tick_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : spike_tick_scheduler
//  Purpose  : Sequences the spike core through a TTFS inference run:
//             IDLE -> RUN -> DRAIN -> [GAP] -> ADVANCE -> RUN ... -> FINISH.
//             Each tick runs until the spike core reports done, then waits
//             for the spike FIFO to empty and the neuron core to go idle,
//             idles tick_gap cycles and strobes next_tick. After the last
//             tick a done pulse is issued and a sticky irq is raised.
//  Ports    : CLK, RSTN            clock, async active-low reset
//             start_i / abort_i    run control pulses (abort has priority)
//             num_ticks_i          ticks per run, latched on accepted start
//             tick_gap_i           idle gap cycles, latched on accepted start
//             spikecore_done_i     spike core finished current tick
//             spikecore_empty_i    spike FIFO empty
//             neuron_busy_i        neuron core still processing
//             irq_clr_i            clears irq_o (a same-cycle set wins)
//             spikecore_working_o  spike core enable
//             tick_o               current tick
//             next_tick_o          one-cycle tick advance strobe
//             busy_o / done_o      run active / completion pulse
//             irq_o                sticky completion interrupt
//             tick_cycles_o, run_cycles_o   (TICK_PROFILE_EN only)
//  Config   : define TICK_PROFILE_EN to add the profiling counters.
//  Revision : 1.0 - initial release
// ============================================================================
module spike_tick_scheduler
  import spike_sched_pkg::*;
#(
  parameter int TICK_W = SCHED_TICK_W,
  parameter int GAP_W  = SCHED_GAP_W
`ifdef TICK_PROFILE_EN
  ,
  parameter int PROF_W = SCHED_PROF_W
`endif
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [TICK_W:0]   num_ticks_i,
  input  logic [GAP_W-1:0]  tick_gap_i,
  input  logic              spikecore_done_i,
  input  logic              spikecore_empty_i,
  input  logic              neuron_busy_i,
  input  logic              irq_clr_i,
  output logic              spikecore_working_o,
  output logic [TICK_W-1:0] tick_o,
  output logic              next_tick_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              irq_o
`ifdef TICK_PROFILE_EN
  ,
  output logic [PROF_W-1:0] tick_cycles_o,
  output logic [PROF_W-1:0] run_cycles_o
`endif
);

  sched_state_e      state_q, state_d;
  sched_cfg_t        cfg_q, cfg_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              working_q, working_d;
  logic              next_tick_q, next_tick_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              irq_q, irq_d;

  logic              w_start_ok;
  logic              w_drain_exit;
  logic [TICK_W:0]   w_last_idx;
  logic              w_last_tick;
  logic              w_gap_zero;

  // num_ticks is never 0 outside IDLE/FINISH, so the subtraction cannot
  // underflow while it matters.
  assign w_last_idx  = (TICK_W+1)'(cfg_q.num_ticks) - (TICK_W+1)'(1);
  assign w_last_tick = ({1'b0, tick_q} == w_last_idx);
  assign w_gap_zero  = (cfg_q.tick_gap == '0);

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    tick_d       = tick_q;
    gap_cnt_d    = gap_cnt_q;
    irq_d        = irq_q;
    w_start_ok   = 1'b0;
    w_drain_exit = 1'b0;

    if (irq_clr_i) begin
      irq_d = 1'b0;
    end

    if (abort_i) begin
      // Abort also swallows a coincident start in IDLE; tick_o is kept.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            w_start_ok      = 1'b1;
            cfg_d.num_ticks = (SCHED_TICK_W+1)'(num_ticks_i);
            cfg_d.tick_gap  = SCHED_GAP_W'(tick_gap_i);
            tick_d          = '0;
            state_d         = (num_ticks_i == '0) ? ST_FINISH : ST_RUN;
          end
        end
        ST_RUN: begin
          if (spikecore_done_i) begin
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (spikecore_empty_i && !neuron_busy_i) begin
            w_drain_exit = 1'b1;
            if (w_last_tick) begin
              state_d = ST_FINISH;
            end else if (w_gap_zero) begin
              state_d = ST_ADVANCE;
            end else begin
              gap_cnt_d = GAP_W'(cfg_q.tick_gap);
              state_d   = ST_GAP;
            end
          end
        end
        ST_GAP: begin
          // Loaded with tick_gap, leaves on 1: exactly tick_gap GAP cycles.
          if (gap_cnt_q <= GAP_W'(1)) begin
            state_d = ST_ADVANCE;
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
          end
        end
        ST_ADVANCE: begin
          tick_d  = tick_q + TICK_W'(1);
          state_d = ST_RUN;
        end
        ST_FINISH: begin
          irq_d   = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Outputs are registered decodes of the next state, so they line up
    // with the state they describe. done trails FINISH by one cycle.
    working_d   = (state_d == ST_RUN);
    next_tick_d = (state_d == ST_ADVANCE);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_q == ST_FINISH) && !abort_i;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= ST_IDLE;
      cfg_q       <= '0;
      tick_q      <= '0;
      gap_cnt_q   <= '0;
      working_q   <= 1'b0;
      next_tick_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      tick_q      <= tick_d;
      gap_cnt_q   <= gap_cnt_d;
      working_q   <= working_d;
      next_tick_q <= next_tick_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      irq_q       <= irq_d;
    end
  end

  assign spikecore_working_o = working_q;
  assign tick_o              = tick_q;
  assign next_tick_o         = next_tick_q;
  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign irq_o               = irq_q;

`ifdef TICK_PROFILE_EN
  spike_tick_prof #(
    .PROF_W (PROF_W)
  ) u_prof (
    .CLK           (CLK),
    .RSTN          (RSTN),
    .clr_i         (w_start_ok),
    .tick_en_i     ((state_q == ST_RUN) || (state_q == ST_DRAIN)),
    .tick_end_i    (w_drain_exit),
    .run_en_i      ((state_q != ST_IDLE) && (state_q != ST_FINISH)),
    .tick_cycles_o (tick_cycles_o),
    .run_cycles_o  (run_cycles_o)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_spike_tick_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spike_tick_scheduler
//  Purpose  : Self-checking bench for spike_tick_scheduler. A behavioural
//             spike-core responder drives done/empty/busy and pushes the
//             cycle at which next_tick_o or done_o must appear; a monitor
//             pops and compares. Table rows cover the main run shapes,
//             hand sequences cover abort, irq and reset corners.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spike_tick_scheduler;

  localparam int TICK_W = 8;
  localparam int GAP_W  = 8;

  logic              CLK = 1'b0;
  logic              RSTN = 1'b0;
  logic              start_i = 1'b0;
  logic              abort_i = 1'b0;
  logic [TICK_W:0]   num_ticks_i = '0;
  logic [GAP_W-1:0]  tick_gap_i = '0;
  logic              spikecore_done_i = 1'b0;
  logic              spikecore_empty_i = 1'b1;
  logic              neuron_busy_i = 1'b0;
  logic              irq_clr_i = 1'b0;
  logic              spikecore_working_o;
  logic [TICK_W-1:0] tick_o;
  logic              next_tick_o;
  logic              busy_o;
  logic              done_o;
  logic              irq_o;
`ifdef TICK_PROFILE_EN
  logic [31:0]       tick_cycles_o;
  logic [31:0]       run_cycles_o;
`endif

  spike_tick_scheduler dut (
    .CLK                 (CLK),
    .RSTN                (RSTN),
    .start_i             (start_i),
    .abort_i             (abort_i),
    .num_ticks_i         (num_ticks_i),
    .tick_gap_i          (tick_gap_i),
    .spikecore_done_i    (spikecore_done_i),
    .spikecore_empty_i   (spikecore_empty_i),
    .neuron_busy_i       (neuron_busy_i),
    .irq_clr_i           (irq_clr_i),
    .spikecore_working_o (spikecore_working_o),
    .tick_o              (tick_o),
    .next_tick_o         (next_tick_o),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .irq_o               (irq_o)
`ifdef TICK_PROFILE_EN
    ,
    .tick_cycles_o       (tick_cycles_o),
    .run_cycles_o        (run_cycles_o)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard queues
  int exp_tick_q[$];
  int exp_nt_q[$];
  int exp_done_q[$];
  int nt_seen = 0;
  int done_seen = 0;

  // Responder configuration (written by the main sequence only)
  int cfg_num = 0, cfg_gap = 0, cfg_dly = 5, cfg_e = 0, cfg_b = 0;

  // Spike-core responder
  initial begin
    int run_cnt, k, rtick;
    bit drain;
    run_cnt = 0; k = 0; rtick = 0; drain = 0;
    forever begin
      @(negedge CLK);
      spikecore_done_i = 1'b0;
      if (!busy_o) begin
        rtick = 0; drain = 0; run_cnt = 0;
      end
      if (drain) begin
        k++;
        spikecore_empty_i = (k > cfg_e);
        neuron_busy_i     = (k > cfg_e) && (k <= cfg_e + cfg_b);
        if (k > cfg_e + cfg_b) drain = 0;
      end else begin
        spikecore_empty_i = 1'b1;
        neuron_busy_i     = 1'b0;
      end
      if (spikecore_working_o) begin
        run_cnt++;
        if (run_cnt == cfg_dly) begin
          spikecore_done_i = 1'b1;
          if (rtick == cfg_num - 1)
            exp_done_q.push_back(cyc + cfg_e + cfg_b + 3);
          else
            exp_nt_q.push_back(cyc + cfg_e + cfg_b + cfg_gap + 2);
          rtick++;
          drain = 1;
          k = 0;
        end
      end else begin
        run_cnt = 0;
      end
    end
  end

  // Output monitor
  initial begin
    bit prev_w;
    prev_w = 0;
    forever begin
      @(negedge CLK);
      if (!RSTN) begin
        prev_w = 0;
        continue;
      end
      if (spikecore_working_o && !prev_w) begin
        check("run_entry_expected", exp_tick_q.size() > 0, 1);
        if (exp_tick_q.size() > 0) check("tick_at_run_entry", tick_o, exp_tick_q.pop_front());
      end
      prev_w = spikecore_working_o;
      if (next_tick_o) begin
        nt_seen++;
        check("next_tick_expected", exp_nt_q.size() > 0, 1);
        if (exp_nt_q.size() > 0) check("next_tick_cycle", cyc, exp_nt_q.pop_front());
      end
      if (done_o) begin
        done_seen++;
        check("done_expected", exp_done_q.size() > 0, 1);
        if (exp_done_q.size() > 0) check("done_cycle", cyc, exp_done_q.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the following negedge with start low.
  task automatic start_run(input int num, input int gap);
    num_ticks_i = (TICK_W+1)'(num);
    tick_gap_i  = GAP_W'(gap);
    start_i     = 1'b1;
    for (int t = 0; t < num; t++) exp_tick_q.push_back(t);
    if (num == 0) exp_done_q.push_back(cyc + 2);
    @(negedge CLK);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy_o || exp_done_q.size() != 0) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check({name, "_in_time"}, n < budget, 1);
    repeat (2) @(negedge CLK);
  endtask

  task automatic clear_irq();
    irq_clr_i = 1'b1;
    @(negedge CLK);
    irq_clr_i = 1'b0;
    check("irq_cleared", irq_o, 0);
  endtask

  typedef struct {
    int num;
    int gap;
    int dly;
    int e;
    int b;
    bit poke;
  } row_t;

  localparam int N_ROWS = 7;
  row_t rows[N_ROWS];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    int nt0, dn0, n;

    rows[0] = '{num: 3,   gap: 0, dly: 5, e: 0,  b: 0, poke: 0};
    rows[1] = '{num: 2,   gap: 4, dly: 5, e: 0,  b: 0, poke: 1};
    rows[2] = '{num: 0,   gap: 0, dly: 5, e: 0,  b: 0, poke: 0};
    rows[3] = '{num: 2,   gap: 0, dly: 5, e: 10, b: 3, poke: 0};
    rows[4] = '{num: 1,   gap: 2, dly: 3, e: 0,  b: 0, poke: 0};
    rows[5] = '{num: 4,   gap: 1, dly: 1, e: 2,  b: 1, poke: 0};
    rows[6] = '{num: 256, gap: 0, dly: 1, e: 0,  b: 0, poke: 0};

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_working", spikecore_working_o, 0);
    check("rst_tick", tick_o, 0);
    check("rst_next_tick", next_tick_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_irq", irq_o, 0);
    RSTN = 1'b1;
    repeat (2) @(negedge CLK);

    // Table-driven runs
    for (int r = 0; r < N_ROWS; r++) begin
      cfg_num = rows[r].num; cfg_gap = rows[r].gap; cfg_dly = rows[r].dly;
      cfg_e = rows[r].e; cfg_b = rows[r].b;
      if (irq_o) clear_irq();
      nt0 = nt_seen; dn0 = done_seen;
      start_run(rows[r].num, rows[r].gap);
      check("busy_after_start", busy_o, 1);
      check("working_after_start", spikecore_working_o, rows[r].num > 0);
      if (rows[r].poke) begin
        // Start while busy must not touch the latched config.
        num_ticks_i = (TICK_W+1)'(7);
        tick_gap_i  = '0;
        start_i     = 1'b1;
        @(negedge CLK);
        start_i = 1'b0;
      end
      wait_idle("run_complete", 5000);
      check("next_tick_count", nt_seen - nt0, (rows[r].num > 0) ? rows[r].num - 1 : 0);
      check("done_count", done_seen - dn0, 1);
      check("irq_set", irq_o, 1);
      check("final_tick", tick_o, (rows[r].num > 0) ? rows[r].num - 1 : 0);
      check("tick_queue_drained", exp_tick_q.size(), 0);
      check("nt_queue_drained", exp_nt_q.size(), 0);
    end

    // Abort during RUN at tick 1
    clear_irq();
    cfg_num = 3; cfg_gap = 0; cfg_dly = 5; cfg_e = 0; cfg_b = 0;
    dn0 = done_seen;
    start_run(3, 0);
    n = 0;
    while (!(spikecore_working_o && tick_o == 1) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("abort_reach_tick1", n < 200, 1);
    abort_i = 1'b1;
    @(negedge CLK);
    abort_i = 1'b0;
    exp_tick_q.delete();
    exp_nt_q.delete();
    exp_done_q.delete();
    check("abort_busy", busy_o, 0);
    check("abort_working", spikecore_working_o, 0);
    check("abort_tick_hold", tick_o, 1);
    repeat (6) @(negedge CLK);
    check("abort_no_done", done_seen - dn0, 0);
    check("abort_irq_unchanged", irq_o, 0);
    cfg_num = 2;
    start_run(2, 0);
    check("restart_tick_cleared", tick_o, 0);
    wait_idle("restart_complete", 500);
    check("restart_done", done_seen - dn0, 1);

    // irq_clr coincident with FINISH: set wins
    check("irq_before_coincident", irq_o, 1);
    cfg_num = 0;
    dn0 = done_seen;
    start_i = 1'b1;
    num_ticks_i = '0;
    exp_done_q.push_back(cyc + 2);
    @(negedge CLK);
    start_i   = 1'b0;
    irq_clr_i = 1'b1;   // this cycle the FSM is in FINISH
    @(negedge CLK);
    irq_clr_i = 1'b0;
    check("irq_set_wins", irq_o, 1);
    repeat (2) @(negedge CLK);
    check("coincident_done", done_seen - dn0, 1);
    clear_irq();

    // abort together with start in IDLE: start discarded
    dn0 = done_seen;
    num_ticks_i = (TICK_W+1)'(2);
    start_i = 1'b1;
    abort_i = 1'b1;
    @(negedge CLK);
    start_i = 1'b0;
    abort_i = 1'b0;
    check("abort_start_busy", busy_o, 0);
    repeat (5) @(negedge CLK);
    check("abort_start_working", spikecore_working_o, 0);
    check("abort_start_no_done", done_seen - dn0, 0);

    // Reset mid-run returns to reset values immediately
    cfg_num = 0;
    start_run(0, 0);
    wait_idle("pre_reset_run", 100);
    check("pre_reset_irq", irq_o, 1);
    cfg_num = 3; cfg_dly = 5;
    start_run(3, 0);
    n = 0;
    while (!(spikecore_working_o && tick_o == 1) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("reset_reach_tick1", n < 200, 1);
    RSTN = 1'b0;
    #1;
    check("midrst_working", spikecore_working_o, 0);
    check("midrst_tick", tick_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_irq", irq_o, 0);
    exp_tick_q.delete();
    exp_nt_q.delete();
    exp_done_q.delete();
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    repeat (3) @(negedge CLK);
    check("post_rst_busy", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
